// File: rtl/mips_rf_pkg.sv
// Shared definitions for the general-purpose register file with scoreboard.
// Holds the control state type, the default geometry and the index of the
// hardwired zero register.
package mips_rf_pkg;

    // CLEAR: post-reset sweep writing zero to every register.
    // RUN:   normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Index of the register that always reads zero.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// Bus between the register file and its clients (decode and writeback).
//   rd_addr/rd_data/rd_pending : NUM_RD packed read ports, port k at [k*W +: W]
//   wr0_*                      : ALU writeback port
//   wr1_*                      : long-latency writeback port (clears pending)
//   pend_set/pend_addr         : marks a register pending at issue
//   ready                      : sweep-clear finished, writes accepted
//   wr_collision               : one-cycle pulse, both ports hit one register
//   dbg_addr/dbg_data          : stored-value debug read, no bypass
// master = the clients, slave = the register file.
interface mips_regfile_sb_if
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     ready;
    logic                     wr_collision;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               pend_set, pend_addr, dbg_addr,
        input  rd_data, rd_pending, ready, wr_collision, dbg_data
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               pend_set, pend_addr, dbg_addr,
        output rd_data, rd_pending, ready, wr_collision, dbg_data
    );
endinterface

// File: rtl/mips_rf_read_port.sv
// One combinational read port of the register file.
//   run            : register file is in normal operation (else reads 0)
//   addr           : read index
//   stored_data    : stored value at addr
//   stored_pending : scoreboard bit at addr
//   w0_*/w1_*      : this cycle's qualified writes (enable already includes
//                    RUN and nonzero index)
//   data/pending   : read result and pending flag
module mips_rf_read_port
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_pending,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic [DATA_W-1:0] data,
    output logic              pending
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic hit0;
    logic hit1;

    assign hit0 = w0_en && (w0_addr == addr);
    assign hit1 = w1_en && (w1_addr == addr);

    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        data    = '0;
        pending = 1'b0;
        if (run && addr != ZERO_IDX) begin
            data    = stored_data;
            pending = stored_pending;
            if (BYPASS != 0) begin
                // Port 0 has priority on a dual match, mirroring the commit.
                if (hit0)
                    data = w0_data;
                else if (hit1)
                    data = w1_data;
                // A long-latency result landing now resolves the hazard.
                if (hit1)
                    pending = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mips_regfile_sb.sv
// General-purpose register file with two write ports, NUM_RD read ports,
// optional write-to-read bypass, a per-register pending scoreboard for
// long-latency results and a post-reset sweep that zeroes every register.
//   clk   : clock
//   reset : synchronous, active-high; restarts the sweep
//   bus   : slave side of mips_regfile_sb_if (reads, writes, scoreboard,
//           ready, wr_collision, debug read)
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    mips_regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state;
    logic [ADDR_W-1:0] clear_idx;
    logic              ready_q;
    logic              collision_q;
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [DATA_W-1:0] regs [DEPTH];

    logic run;
    logic w0_ok;
    logic w1_ok;
    logic same_idx;

    assign run      = (state == RUN);
    assign w0_ok    = run && bus.wr0_en && (bus.wr0_addr != ZERO_IDX);
    assign w1_ok    = run && bus.wr1_en && (bus.wr1_addr != ZERO_IDX);
    assign same_idx = (bus.wr0_addr == bus.wr1_addr);

    // Scoreboard update: clear on a long-latency write, then set, so an
    // issue to the same register in the same cycle keeps it pending.
    always_comb begin
        pending_next = pending;
        if (w1_ok)
            pending_next[bus.wr1_addr] = 1'b0;
        if (run && bus.pend_set && bus.pend_addr != ZERO_IDX)
            pending_next[bus.pend_addr] = 1'b1;
    end

    // Control: sweep state machine, scoreboard and registered status.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            clear_idx   <= ADDR_W'(1);
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
            pending     <= '0;
        end else begin
            collision_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clear_idx <= clear_idx + ADDR_W'(1);
                    if (clear_idx == LAST_IDX) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    collision_q <= w0_ok && w1_ok && same_idx;
                    pending     <= pending_next;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the storage array has no reset; it is zeroed by the sweep, which
    // keeps it a plain write-enabled array rather than DEPTH resettable flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clear_idx] <= '0;
            end else begin
                // Port 0 wins a same-index collision.
                if (w1_ok && !(w0_ok && same_idx))
                    regs[bus.wr1_addr] <= bus.wr1_data;
                if (w0_ok)
                    regs[bus.wr0_addr] <= bus.wr0_data;
            end
        end
    end

    logic [DATA_W-1:0] rd_data_arr [NUM_RD];
    logic              rd_pend_arr [NUM_RD];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

        mips_rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rd (
            .run            (run),
            .addr           (addr),
            .stored_data    (regs[addr]),
            .stored_pending (pending[addr]),
            .w0_en          (w0_ok),
            .w0_addr        (bus.wr0_addr),
            .w0_data        (bus.wr0_data),
            .w1_en          (w1_ok),
            .w1_addr        (bus.wr1_addr),
            .w1_data        (bus.wr1_data),
            .data           (rd_data_arr[k]),
            .pending        (rd_pend_arr[k])
        );
    end

    always_comb begin
        bus.rd_data    = '0;
        bus.rd_pending = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = rd_data_arr[k];
            bus.rd_pending[k]               = rd_pend_arr[k];
        end
    end

    assign bus.dbg_data     = (run && bus.dbg_addr != ZERO_IDX) ? regs[bus.dbg_addr] : '0;
    assign bus.ready        = ready_q;
    assign bus.wr_collision = collision_q;
endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised successor to the core's general-purpose register file.
- Provides N combinational read ports and two write ports:
  - port 0: ALU writeback, single-cycle results.
  - port 1: long-latency writeback (loads, mult/div moves).
- Adds optional write-to-read bypass and a per-register pending scoreboard, so decode can detect RAW hazards on long-latency results.
- Adds a post-reset sweep-clear state machine. Sits between decode (reads, pending check) and writeback (writes, pending clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = read of a register being written this cycle returns the new data; 0 = returns the stored value.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- rd_addr, in, NUM_RD*ADDR_W, packed read indices; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W, packed read data, same packing as rd_addr.
- rd_pending, out, NUM_RD, 1 = register at port k has an outstanding long-latency write.
- wr0_en, in, 1, port 0 write enable.
- wr0_addr, in, ADDR_W, port 0 write index.
- wr0_data, in, DATA_W, port 0 write data.
- wr1_en, in, 1, port 1 write enable.
- wr1_addr, in, ADDR_W, port 1 write index.
- wr1_data, in, DATA_W, port 1 write data.
- pend_set, in, 1, marks pend_addr pending (long-latency instruction issued).
- pend_addr, in, ADDR_W, index to mark pending.
- ready, out, 1, 1 = clear sweep finished; writes accepted.
- wr_collision, out, 1, registered one-cycle pulse: both ports wrote the same nonzero index.
- dbg_addr, in, ADDR_W, debug read index.
- dbg_data, out, DATA_W, combinational debug read of the stored value; no bypass.

Behaviour:
- Reset/state machine:
  - States CLEAR and RUN.
  - reset=1 at an edge → state CLEAR, clear_idx=1, all pending bits 0, ready=0, wr_collision=0.
  - Reset mid-sweep or mid-RUN restarts the sweep.
  - CLEAR: each cycle writes 0 to reg[clear_idx] and increments clear_idx. When clear_idx reaches DEPTH-1 that edge writes it and moves to RUN. The sweep therefore takes DEPTH-1 cycles (31 at the default ADDR_W) after reset deasserts.
  - During CLEAR: wr0/wr1/pend_set are ignored, rd_data=0, rd_pending=0, dbg_data=0.
  - RUN: ready=1, normal operation; no exit except reset.
- Register 0:
  - Reads always return 0 and its pending bit never sets.
  - Writes and pend_set to index 0 are dropped; they do not raise wr_collision.
- Writes (RUN only):
  - Committed at the rising edge.
  - Both ports enabled to the same index → port 0 data wins, and wr_collision=1 on the next cycle for exactly one cycle.
  - Different indices → both commit.
- Reads:
  - Combinational, zero latency.
  - BYPASS=1: if the read index is nonzero and matches an enabled write this cycle, return that write data; on a dual match, return port 0 data. Otherwise return the stored value.
  - BYPASS=0: always return the stored value.
- Scoreboard (RUN only):
  - pend_set sets pending[pend_addr] at the edge.
  - A wr1_en write clears pending[wr1_addr]; a port 0 write never clears.
  - Same index set and cleared in one cycle → set wins.
  - rd_pending[k] = pending[rd_addr_k]; when BYPASS=1 it is masked to 0 if wr1 clears that index this cycle.

Decomposition:
- Shared package mips_rf_pkg holds:
  - rf_state_t enum (CLEAR, RUN);
  - default constants DATA_W=32 and ADDR_W=5;
  - the REG_ZERO index constant.
- One natural sub-module: mips_rf_read_port, one read mux with bypass logic, instantiated NUM_RD times via generate.

Test Plan:
- Pulse reset 1 cycle, then count → ready rises after exactly 31 cycles; all 32 registers read 0; rd_pending=0.
- Port 0 writes 0xDEADBEEF to r5; next cycle read r5 on both ports → 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- BYPASS=1: same cycle wr0 r7=0xA5A5A5A5 and rd_addr0=7 → rd_data0=0xA5A5A5A5 combinationally; dbg_data(r7) still shows the old value until the edge.
- wr0 and wr1 both to r9 (0x11, 0x22) → r9=0x11, wr_collision high for one cycle only.
- pend_set r3, then rd r3 → rd_pending=1. A wr0 to r3 leaves it pending. wr1 r3=0x55 → pending clears; with BYPASS=1, rd_pending=0 and data 0x55 in the same cycle. pend_set and wr1 to r3 together → stays pending.
- Assert reset mid-RUN with r4 pending and r4=0x99 → ready=0, pending cleared; after the 31-cycle sweep r4 reads 0. Writes issued during the sweep are dropped.
